// File: rtl/fmad_issue.sv
// Single-outstanding command sequencer in front of the fmad datapath: holds operands
// for the pipeline latency, captures the result, and keeps sticky IEEE exception flags.
module fmad_issue #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned TAG_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_op,
   input  logic [31:0]      cmd_x,
   input  logic [31:0]      cmd_y,
   input  logic [31:0]      cmd_z,
   input  logic [31:0]      cmd_w,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic             fma_req,
   output logic [31:0]      fma_command,
   output logic [31:0]      fma_x,
   output logic [31:0]      fma_y,
   output logic [31:0]      fma_z,
   output logic [31:0]      fma_w,
   input  logic [31:0]      fma_rslt,
   input  logic [4:0]       fma_flag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_rslt,
   output logic [4:0]       resp_flag,
   output logic [TAG_W-1:0] resp_tag,
   output logic [4:0]       fflags,
   input  logic             fflags_clr,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [4:0] FLAG_NV = 5'b10000;

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic       accept;
   logic       op_known;
   logic       capture;
   logic [4:0] ff_new;

   always_comb begin
      state_nxt  = state;
      cmd_ready  = 1'b0;
      fma_req    = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      op_known   = (cmd_op == 32'd1) || (cmd_op == 32'd13);
      capture    = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = op_known ? ISSUE : DONE;
            end
         end
         ISSUE: begin
            fma_req   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == 4'(LATENCY)) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Unknown ops report NV; only scalar FMA results feed the sticky flags.
   always_comb begin
      ff_new = '0;
      if (capture && fma_command == 32'd1) ff_new = fma_flag;
      if (accept && !op_known)             ff_new = FLAG_NV;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         fma_command <= '0;
         fma_x       <= '0;
         fma_y       <= '0;
         fma_z       <= '0;
         fma_w       <= '0;
         resp_rslt   <= '0;
         resp_flag   <= '0;
         resp_tag    <= '0;
         fflags      <= '0;
      end else begin
         state <= state_nxt;
         if (state == ISSUE)     cnt <= 4'd1;
         else if (state == WAIT) cnt <= cnt + 4'd1;
         else if (state == IDLE) cnt <= '0;
         if (accept) begin
            fma_command <= cmd_op;
            fma_x       <= cmd_x;
            fma_y       <= cmd_y;
            fma_z       <= cmd_z;
            fma_w       <= cmd_w;
            resp_tag    <= cmd_tag;
            if (!op_known) begin
               resp_rslt <= '0;
               resp_flag <= FLAG_NV;
            end
         end
         if (capture) begin
            resp_rslt <= fma_rslt;
            resp_flag <= fma_flag;
         end
         // A clear colliding with new flags keeps only the new flags.
         if (fflags_clr) fflags <= ff_new;
         else            fflags <= fflags | ff_new;
      end
   end

endmodule

// File: tb/tb_fmad_issue.sv
// Directed bench for fmad_issue; a tiny fmad stand-in presents the result only on the
// LATENCY-th cycle after req so mistimed capture is visible.
module tb_fmad_issue;

   localparam int unsigned LAT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_op, cmd_x, cmd_y, cmd_z, cmd_w;
   logic [3:0]  cmd_tag;
   logic        fma_req;
   logic [31:0] fma_command, fma_x, fma_y, fma_z, fma_w;
   logic [31:0] fma_rslt;
   logic [4:0]  fma_flag;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rslt;
   logic [4:0]  resp_flag;
   logic [3:0]  resp_tag;
   logic [4:0]  fflags;
   logic        fflags_clr;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl_rslt;
   logic [4:0]  mdl_flag;
   int unsigned tcnt;

   fmad_issue #(.LATENCY(LAT), .TAG_W(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_w(cmd_w), .cmd_tag(cmd_tag),
      .fma_req(fma_req), .fma_command(fma_command),
      .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z), .fma_w(fma_w),
      .fma_rslt(fma_rslt), .fma_flag(fma_flag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rslt(resp_rslt),
      .resp_flag(resp_flag), .resp_tag(resp_tag),
      .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset)                       tcnt <= 0;
      else if (fma_req)                tcnt <= 1;
      else if (tcnt != 0 && tcnt < 15) tcnt <= tcnt + 1;
   end

   always_comb begin
      if (tcnt == LAT) begin
         fma_rslt = mdl_rslt;
         fma_flag = mdl_flag;
      end else begin
         fma_rslt = 32'hDEADBEEF;
         fma_flag = 5'b01110;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_cmd(input logic [31:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic [31:0] w, input logic [3:0] tag,
                          input logic [31:0] rslt, input logic [4:0] flag,
                          input logic [4:0] exp_ff, input int unsigned hold, input bit clr_cap);
      int unsigned n;
      bit known;
      known    = (op == 32'd1) || (op == 32'd13);
      mdl_rslt = rslt;
      mdl_flag = flag;
      @(negedge clk);
      check("ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_z = z; cmd_w = w; cmd_tag = tag;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_x = 32'hBAD0BAD0; cmd_op = 32'd99;
      check("req_c1", 32'(fma_req), 32'(known));
      check("busy_c1", 32'(busy), 32'd1);
      check("fma_cmd", fma_command, op);
      check("fma_x", fma_x, x);
      check("fma_w", fma_w, w);
      if (known) begin
         n = 0;
         do begin
            @(negedge clk);
            fflags_clr = 1'b0;
            n++;
            if (fma_req) check("req_once", 32'(fma_req), 32'd0);
            if (clr_cap && n == LAT) fflags_clr = 1'b1;
         end while (!resp_valid && n < 20);
         check("latency", n, LAT + 1);
      end
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_rslt", resp_rslt, rslt);
      check("resp_flag", 32'(resp_flag), 32'(flag));
      check("resp_tag", 32'(resp_tag), 32'(tag));
      check("fflags", 32'(fflags), 32'(exp_ff));
      check("ready_done", 32'(cmd_ready), 32'd0);
      for (int unsigned i = 0; i < hold; i++) begin
         cmd_valid = 1'b1; cmd_x = 32'h55555555; cmd_op = 32'd1;
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rslt", resp_rslt, rslt);
         check("hold_flag", 32'(resp_flag), 32'(flag));
         check("hold_tag", 32'(resp_tag), 32'(tag));
         check("hold_ready", 32'(cmd_ready), 32'd0);
         check("hold_x", fma_x, x);
         check("hold_y", fma_y, y);
      end
      cmd_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(cmd_ready), 32'd1);
      check("idle_valid", 32'(resp_valid), 32'd0);
      check("idle_x", fma_x, x);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; resp_ready = 1'b0; fflags_clr = 1'b0;
      cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_z = '0; cmd_w = '0; cmd_tag = '0;
      mdl_rslt = '0; mdl_flag = '0;
      #12;
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_req", 32'(fma_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fflags", 32'(fflags), 32'd0);
      check("rst_rslt", resp_rslt, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // 1.0*2.0+3.0 = 5.0
      run_cmd(32'd1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0, 4'h1,
              32'h40A00000, 5'b00000, 5'b00000, 0, 1'b0);
      // inf*0 -> invalid, default NaN
      run_cmd(32'd1, 32'h7F800000, 32'h00000000, 32'h3F800000, 32'h0, 4'h2,
              32'hFFC00000, 5'b10000, 5'b10000, 0, 1'b0);
      // 1.0*1.0 + tiny -> inexact, sticky keeps NV
      run_cmd(32'd1, 32'h3F800000, 32'h3F800000, 32'h30800000, 32'h0, 4'h4,
              32'h3F800000, 5'b00001, 5'b10001, 0, 1'b0);
      // packed dot under backpressure: flags reported but not accumulated
      run_cmd(32'd13, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'hA,
              32'h12345678, 5'b00101, 5'b10001, 10, 1'b0);

      @(negedge clk); fflags_clr = 1'b1;
      @(negedge clk); fflags_clr = 1'b0;
      check("clr_alone", 32'(fflags), 32'd0);

      // unknown op answers next cycle with NV
      run_cmd(32'd7, 32'hCAFEF00D, 32'h1, 32'h2, 32'h3, 4'h3,
              32'h0, 5'b10000, 5'b10000, 0, 1'b0);
      // clear on the capture edge keeps only the new NX
      run_cmd(32'd1, 32'h3F800000, 32'h3F800000, 32'h30800000, 32'h0, 4'h5,
              32'h3F800000, 5'b00001, 5'b00001, 0, 1'b1);

      // async reset in WAIT with counter at 2
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 32'd1; cmd_x = 32'h40000000; cmd_y = 32'h40000000;
      cmd_z = 32'h0; cmd_w = 32'h0; cmd_tag = 4'h6;
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_x", fma_x, 32'd0);
      check("arst_cmd", fma_command, 32'd0);
      check("arst_fflags", 32'(fflags), 32'd0);
      check("arst_tag", 32'(resp_tag), 32'd0);
      @(negedge clk); reset = 1'b0;
      repeat (6) @(negedge clk);
      check("arst_noresp", 32'(resp_valid), 32'd0);
      run_cmd(32'd1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0, 4'h7,
              32'h40A00000, 5'b00000, 5'b00000, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
